// File: rtl/exc_flush_ctrl.sv
// Exception/interrupt/eret sequencer: flushes the pipeline, latches EPC/cause and redirects the PC.
// Trigger at edge N -> EXC_flush high for FLUSH_CYCLES cycles -> one-cycle redirect strobe; new triggers are held off while busy.
module exc_flush_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [31:0] pc_M,
    input  logic        bd_M,
    input  logic        exc_valid_M,
    input  logic [4:0]  exc_code_M,
    input  logic        eret_M,
    input  logic [5:0]  int_req,
    input  logic        cfg_we,
    input  logic [6:0]  cfg_wdata,
    output logic        EXC_flush,
    output logic        pc_redirect_valid,
    output logic [31:0] pc_redirect,
    output logic [31:0] epc,
    output logic [4:0]  cause_code,
    output logic        cause_bd,
    output logic [5:0]  cause_ip,
    output logic [7:0]  status,
    output logic        busy
);
    typedef enum logic [1:0] {RUN, FLUSH, REDIRECT} state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] target, target_nxt;
    logic        ie, ie_nxt;
    logic        exl, exl_nxt;
    logic [5:0]  im, im_nxt;
    logic        flush_nxt, prv_nxt, bd_nxt, busy_nxt;
    logic [31:0] pcr_nxt, epc_nxt;
    logic [4:0]  code_nxt;
    logic        int_take, exc_take, eret_take;

    assign status = {exl, ie, im};

    always_comb begin
        int_take   = (state == RUN) && m_valid && ie && !exl && (|(int_req & im));
        exc_take   = (state == RUN) && m_valid && exc_valid_M && !int_take;
        eret_take  = (state == RUN) && m_valid && eret_M && !int_take && !exc_take;

        state_nxt  = state;
        cnt_nxt    = cnt;
        target_nxt = target;
        ie_nxt     = ie;
        exl_nxt    = exl;
        im_nxt     = im;
        flush_nxt  = EXC_flush;
        prv_nxt    = 1'b0;
        pcr_nxt    = pc_redirect;
        epc_nxt    = epc;
        code_nxt   = cause_code;
        bd_nxt     = cause_bd;

        case (state)
            RUN: begin
                if (int_take || exc_take) begin
                    // A nested event keeps the original return point intact.
                    if (!exl) begin
                        epc_nxt = bd_M ? (pc_M - 32'd4) : pc_M;
                        bd_nxt  = bd_M;
                    end
                    code_nxt   = int_take ? 5'd0 : exc_code_M;
                    exl_nxt    = 1'b1;
                    target_nxt = HANDLER_ADDR;
                    state_nxt  = FLUSH;
                    flush_nxt  = 1'b1;
                    cnt_nxt    = CNT_INIT;
                end else if (eret_take) begin
                    exl_nxt    = 1'b0;
                    target_nxt = epc;
                    state_nxt  = FLUSH;
                    flush_nxt  = 1'b1;
                    cnt_nxt    = CNT_INIT;
                end
            end
            FLUSH: begin
                if (cnt == 4'd0) begin
                    flush_nxt = 1'b0;
                    prv_nxt   = 1'b1;
                    pcr_nxt   = target;
                    state_nxt = REDIRECT;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            REDIRECT: state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase

        if (cfg_we) begin
            {ie_nxt, im_nxt} = cfg_wdata;
        end

        busy_nxt = (state_nxt != RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= RUN;
            cnt               <= 4'd0;
            target            <= 32'd0;
            ie                <= 1'b0;
            exl               <= 1'b0;
            im                <= 6'd0;
            EXC_flush         <= 1'b0;
            pc_redirect_valid <= 1'b0;
            pc_redirect       <= 32'd0;
            epc               <= 32'd0;
            cause_code        <= 5'd0;
            cause_bd          <= 1'b0;
            cause_ip          <= 6'd0;
            busy              <= 1'b0;
        end else begin
            state             <= state_nxt;
            cnt               <= cnt_nxt;
            target            <= target_nxt;
            ie                <= ie_nxt;
            exl               <= exl_nxt;
            im                <= im_nxt;
            EXC_flush         <= flush_nxt;
            pc_redirect_valid <= prv_nxt;
            pc_redirect       <= pcr_nxt;
            epc               <= epc_nxt;
            cause_code        <= code_nxt;
            cause_bd          <= bd_nxt;
            cause_ip          <= int_req;
            busy              <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Bench for exc_flush_ctrl: directed scenarios plus a randomized run against an event-timeline model.
module tb_exc_flush_ctrl;
    localparam int FC_A = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid, bd_M, exc_valid_M, eret_M, cfg_we;
    logic [31:0] pc_M;
    logic [4:0]  exc_code_M;
    logic [5:0]  int_req;
    logic [6:0]  cfg_wdata;

    logic        a_flush, a_prv, a_bd, a_busy;
    logic [31:0] a_pcr, a_epc;
    logic [4:0]  a_code;
    logic [5:0]  a_ip;
    logic [7:0]  a_status;
    logic        b_flush, b_prv, b_bd, b_busy;
    logic [31:0] b_pcr, b_epc;
    logic [4:0]  b_code;
    logic [5:0]  b_ip;
    logic [7:0]  b_status;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining busy cycles after an event (flush cycles + one redirect cycle).
    int          m_rem;
    logic        m_ie, m_exl, m_bd;
    logic [5:0]  m_im, m_ip;
    logic [31:0] m_epc, m_target, m_pcr;
    logic [4:0]  m_code;

    always #5 clk = ~clk;

    exc_flush_ctrl u_dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .pc_M(pc_M), .bd_M(bd_M),
        .exc_valid_M(exc_valid_M), .exc_code_M(exc_code_M), .eret_M(eret_M),
        .int_req(int_req), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata),
        .EXC_flush(a_flush), .pc_redirect_valid(a_prv), .pc_redirect(a_pcr),
        .epc(a_epc), .cause_code(a_code), .cause_bd(a_bd), .cause_ip(a_ip),
        .status(a_status), .busy(a_busy)
    );

    exc_flush_ctrl #(.FLUSH_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .m_valid(m_valid), .pc_M(pc_M), .bd_M(bd_M),
        .exc_valid_M(exc_valid_M), .exc_code_M(exc_code_M), .eret_M(eret_M),
        .int_req(int_req), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata),
        .EXC_flush(b_flush), .pc_redirect_valid(b_prv), .pc_redirect(b_pcr),
        .epc(b_epc), .cause_code(b_code), .cause_bd(b_bd), .cause_ip(b_ip),
        .status(b_status), .busy(b_busy)
    );

    task automatic model_update();
        logic it, et, rt;
        if (reset) begin
            m_rem = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_im = 0; m_ip = 0;
            m_epc = 0; m_target = 0; m_pcr = 0; m_code = 0;
        end else begin
            it = (m_rem == 0) && m_valid && m_ie && !m_exl && ((int_req & m_im) != 6'd0);
            et = (m_rem == 0) && m_valid && exc_valid_M && !it;
            rt = (m_rem == 0) && m_valid && eret_M && !it && !et;
            m_ip = int_req;
            if (m_rem != 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 1) m_pcr = m_target;
            end
            if (it || et) begin
                if (!m_exl) begin
                    m_epc = bd_M ? pc_M - 32'd4 : pc_M;
                    m_bd  = bd_M;
                end
                m_code   = it ? 5'd0 : exc_code_M;
                m_exl    = 1'b1;
                m_target = 32'h0000_4180;
                m_rem    = FC_A + 1;
            end else if (rt) begin
                m_target = m_epc;
                m_exl    = 1'b0;
                m_rem    = FC_A + 1;
            end
            if (cfg_we) {m_ie, m_im} = cfg_wdata;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m_valid = 0; pc_M = 0; bd_M = 0; exc_valid_M = 0; exc_code_M = 0;
        eret_M = 0; int_req = 0; cfg_we = 0; cfg_wdata = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic fire(input logic mv, input logic [31:0] pc, input logic bd,
                        input logic exc, input logic [4:0] code, input logic er);
        m_valid = mv; pc_M = pc; bd_M = bd; exc_valid_M = exc; exc_code_M = code; eret_M = er;
        tick();
        m_valid = 0; bd_M = 0; exc_valid_M = 0; eret_M = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_flush, a_prv, a_pcr, a_epc, a_code, a_bd, a_ip, a_status, a_busy} !== 87'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0",
                {a_flush, a_prv, a_pcr, a_epc, a_code, a_bd, a_ip, a_status, a_busy});
        end
    endtask

    task automatic test_exception();
        fire(1'b1, 32'h3010, 1'b0, 1'b1, 5'd4, 1'b0);
        checks++; if (a_flush !== 1'b1) begin errors++; $display("FAIL exc_flush: got %b expected 1", a_flush); end
        checks++; if (a_prv !== 1'b0) begin errors++; $display("FAIL exc_prv_early: got %b expected 0", a_prv); end
        checks++; if (a_epc !== 32'h3010) begin errors++; $display("FAIL exc_epc: got %h expected 00003010", a_epc); end
        checks++; if (a_code !== 5'd4) begin errors++; $display("FAIL exc_code: got %0d expected 4", a_code); end
        checks++; if (a_status[7] !== 1'b1) begin errors++; $display("FAIL exc_exl: got %b expected 1", a_status[7]); end
        tick();
        checks++; if ({a_flush, a_prv} !== 2'b01) begin errors++; $display("FAIL exc_redirect_strobe: got %b expected 01", {a_flush, a_prv}); end
        checks++; if (a_pcr !== 32'h4180) begin errors++; $display("FAIL exc_redirect_pc: got %h expected 00004180", a_pcr); end
        tick();
        checks++; if ({a_prv, a_busy} !== 2'b00) begin errors++; $display("FAIL exc_back_to_run: got %b expected 00", {a_prv, a_busy}); end
    endtask

    task automatic test_nested();
        fire(1'b1, 32'h4190, 1'b0, 1'b1, 5'd5, 1'b0);
        checks++; if (a_epc !== 32'h3010) begin errors++; $display("FAIL nested_epc: got %h expected 00003010", a_epc); end
        checks++; if (a_code !== 5'd5) begin errors++; $display("FAIL nested_code: got %0d expected 5", a_code); end
        tick();
        checks++; if (a_pcr !== 32'h4180 || a_prv !== 1'b1) begin errors++; $display("FAIL nested_redirect: got %h/%b expected 00004180/1", a_pcr, a_prv); end
        tick();
    endtask

    task automatic test_eret();
        fire(1'b1, 32'h4200, 1'b0, 1'b0, 5'd0, 1'b1);
        checks++; if (a_status[7] !== 1'b0) begin errors++; $display("FAIL eret_exl: got %b expected 0", a_status[7]); end
        checks++; if (a_flush !== 1'b1) begin errors++; $display("FAIL eret_flush: got %b expected 1", a_flush); end
        tick();
        checks++; if (a_pcr !== 32'h3010 || a_prv !== 1'b1) begin errors++; $display("FAIL eret_redirect: got %h/%b expected 00003010/1", a_pcr, a_prv); end
        tick();
    endtask

    task automatic test_delay_slot();
        fire(1'b1, 32'h3020, 1'b1, 1'b1, 5'd6, 1'b0);
        checks++; if (a_epc !== 32'h301C) begin errors++; $display("FAIL ds_epc: got %h expected 0000301c", a_epc); end
        checks++; if (a_bd !== 1'b1) begin errors++; $display("FAIL ds_bd: got %b expected 1", a_bd); end
        tick(); tick();
        fire(1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
        tick(); tick();
        fire(1'b1, 32'h0, 1'b1, 1'b1, 5'd6, 1'b0);
        checks++; if (a_epc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL ds_wrap_epc: got %h expected fffffffc", a_epc); end
        tick(); tick();
        fire(1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
        tick(); tick();
    endtask

    task automatic test_interrupt();
        cfg_we = 1; cfg_wdata = 7'b1_000100;
        tick();
        cfg_we = 0;
        checks++; if (a_status !== 8'b0_1_000100) begin errors++; $display("FAIL int_cfg_status: got %b expected 01000100", a_status); end
        int_req = 6'b000100;
        fire(1'b1, 32'h3040, 1'b0, 1'b1, 5'd4, 1'b0);
        checks++; if (a_code !== 5'd0) begin errors++; $display("FAIL int_priority_code: got %0d expected 0", a_code); end
        checks++; if (a_ip !== 6'b000100) begin errors++; $display("FAIL int_cause_ip: got %b expected 000100", a_ip); end
        checks++; if (a_epc !== 32'h3040) begin errors++; $display("FAIL int_epc: got %h expected 00003040", a_epc); end
        int_req = 0;
        tick(); tick();
        fire(1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
        tick(); tick();
    endtask

    task automatic test_masked_bubble();
        cfg_we = 1; cfg_wdata = 7'b0_000100;
        tick();
        cfg_we = 0; int_req = 6'b000100; m_valid = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({a_flush, a_busy} !== 2'b00) begin errors++; $display("FAIL masked_no_flush: got %b expected 00", {a_flush, a_busy}); end
        end
        m_valid = 0; cfg_we = 1; cfg_wdata = 7'b1_000100;
        tick();
        cfg_we = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (a_flush !== 1'b0) begin errors++; $display("FAIL bubble_no_flush: got %b expected 0", a_flush); end
        end
        fire(1'b1, 32'h3060, 1'b0, 1'b0, 5'd0, 1'b0);
        checks++; if (a_flush !== 1'b1 || a_code !== 5'd0) begin errors++; $display("FAIL bubble_then_taken: got %b/%0d expected 1/0", a_flush, a_code); end
        int_req = 0;
        tick(); tick();
        fire(1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
        tick(); tick();
    endtask

    task automatic test_busy_defer();
        fire(1'b1, 32'h3080, 1'b0, 1'b1, 5'd7, 1'b0);
        tick(); tick();
        fire(1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
        int_req = 6'b000100; m_valid = 1;
        checks++; if (a_flush !== 1'b1) begin errors++; $display("FAIL defer_flush: got %b expected 1", a_flush); end
        tick();
        checks++; if (a_prv !== 1'b1 || a_code !== 5'd7) begin errors++; $display("FAIL defer_ignored_in_flush: got %b/%0d expected 1/7", a_prv, a_code); end
        tick();
        checks++; if ({a_flush, a_prv, a_busy} !== 3'b000) begin errors++; $display("FAIL defer_ignored_in_redirect: got %b expected 000", {a_flush, a_prv, a_busy}); end
        tick();
        checks++; if (a_flush !== 1'b1 || a_code !== 5'd0) begin errors++; $display("FAIL defer_taken: got %b/%0d expected 1/0", a_flush, a_code); end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_flush3();
        do_reset();
        fire(1'b1, 32'h100, 1'b0, 1'b1, 5'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++; if ({b_flush, b_prv} !== 2'b10) begin errors++; $display("FAIL flush3_cycle%0d: got %b expected 10", i, {b_flush, b_prv}); end
            tick();
        end
        checks++; if ({b_flush, b_prv} !== 2'b01 || b_pcr !== 32'h4180) begin errors++; $display("FAIL flush3_redirect: got %b/%h expected 01/00004180", {b_flush, b_prv}, b_pcr); end
        tick();
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        fire(1'b1, 32'h500, 1'b0, 1'b1, 5'd8, 1'b0);
        tick();
        checks++; if (b_flush !== 1'b1) begin errors++; $display("FAIL midrst_pre_flush: got %b expected 1", b_flush); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({b_flush, b_prv, b_pcr, b_epc, b_code, b_bd, b_ip, b_status, b_busy} !== 87'd0) begin
            errors++; $display("FAIL midrst_async_clear: got %h expected 0",
                {b_flush, b_prv, b_pcr, b_epc, b_code, b_bd, b_ip, b_status, b_busy});
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 1) reset = 1'b0;
            checks++; if (b_prv !== 1'b0) begin errors++; $display("FAIL midrst_no_redirect: got %b expected 0", b_prv); end
        end
    endtask

    task automatic test_random();
        logic [86:0] exp_v, got_v;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            reset       = ($urandom_range(0, 63) == 0);
            m_valid     = ($urandom_range(0, 3) != 0);
            pc_M        = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom & 32'hFFFF_FFFC);
            bd_M        = 1'($urandom);
            exc_valid_M = ($urandom_range(0, 3) == 0);
            exc_code_M  = 5'($urandom);
            eret_M      = ($urandom_range(0, 4) == 0);
            int_req     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            cfg_we      = ($urandom_range(0, 7) == 0);
            cfg_wdata   = 7'($urandom);
            tick();
            exp_v = {m_rem > 1, m_rem == 1, m_pcr, m_epc, m_code, m_bd, m_ip,
                     m_exl, m_ie, m_im, m_rem != 0};
            got_v = {a_flush, a_prv, a_pcr, a_epc, a_code, a_bd, a_ip, a_status, a_busy};
            checks++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, got_v, exp_v);
            end
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_exception();
        test_nested();
        test_eret();
        test_delay_slot();
        test_interrupt();
        test_masked_bubble();
        test_busy_defer();
        test_flush3();
        test_reset_mid_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exc_flush_ctrl.md
Name: exc_flush_ctrl

Overview:
- Exception/interrupt sequencer for the 5-stage pipeline.
- Watches the M stage for exceptions, hardware interrupts and eret.
- Drives EXC_flush to every pipeline register, captures EPC and cause, and issues a one-cycle PC redirect to the handler or to EPC.
- Owns the ie/exl/im status bits. Configuration is written by the M-stage mtc0 path.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, exception/interrupt handler entry PC.
- FLUSH_CYCLES, 1, cycles EXC_flush is held high per event; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m_valid  in  1  M stage holds a real instruction (not a bubble).
- pc_M  in  32  PC of the M-stage instruction.
- bd_M  in  1  M-stage instruction is in a branch delay slot.
- exc_valid_M  in  1  M-stage instruction raised a synchronous exception.
- exc_code_M  in  5  ExcCode of that exception.
- eret_M  in  1  M-stage instruction is eret.
- int_req  in  6  hardware interrupt lines, level-sensitive.
- cfg_we  in  1  status write strobe.
- cfg_wdata  in  7  {ie, im[5:0]}.
- EXC_flush  out  1  clear all pipeline registers at the next edge.
- pc_redirect_valid  out  1  one-cycle strobe; PC loads pc_redirect.
- pc_redirect  out  32  redirect target.
- epc  out  32  exception PC register.
- cause_code  out  5  latched ExcCode; 0 = interrupt.
- cause_bd  out  1  latched BD bit.
- cause_ip  out  6  int_req, registered every cycle.
- status  out  8  {exl, ie, im[5:0]}.
- busy  out  1  state != RUN.

Behaviour:
- All outputs are registered.
- Reset values (async, immediate): state RUN; EXC_flush 0; pc_redirect_valid 0; pc_redirect 0; epc 0; cause_code 0; cause_bd 0; cause_ip 0; ie 0; exl 0; im 0; busy 0.
- States: RUN, FLUSH, REDIRECT.
- Trigger evaluation happens in RUN only, gated by m_valid. Priority order:
  - int_take = ie & ~exl & |(int_req & im) (highest).
  - exc_take = exc_valid_M.
  - eret_take = eret_M (lowest).
- Any trigger at edge N:
  - state <= FLUSH.
  - EXC_flush <= 1.
  - counter <= FLUSH_CYCLES-1.
  - The pipeline sees EXC_flush from cycle N+1.
- On int_take or exc_take:
  - If exl == 0: epc <= bd_M ? pc_M-4 : pc_M, and cause_bd <= bd_M.
  - If exl == 1 (nested exception): epc and cause_bd are unchanged.
  - cause_code <= int_take ? 0 : exc_code_M.
  - exl <= 1.
  - Target latched as HANDLER_ADDR.
- On eret_take: target latched as the current epc; exl <= 0.
- FLUSH:
  - Counter decrements each cycle.
  - When the counter is 0: EXC_flush <= 0, state <= REDIRECT, pc_redirect_valid <= 1, pc_redirect <= target.
  - EXC_flush is high for exactly FLUSH_CYCLES cycles.
  - All triggers are ignored.
- REDIRECT:
  - Lasts one cycle with pc_redirect_valid high.
  - Next state is RUN with pc_redirect_valid 0.
  - Triggers are still ignored in this cycle.
- Latency: trigger edge N → EXC_flush high during cycles N+1..N+FLUSH_CYCLES → pc_redirect_valid high in cycle N+FLUSH_CYCLES+1.
- Configuration writes:
  - cfg_we updates ie and im in any state, at the next edge.
  - cfg_we in the same cycle as a trigger: ie/im take cfg_wdata; exl follows the trigger.
- Interrupts:
  - An interrupt with m_valid=0 (bubble in M) is not taken; it is re-evaluated each cycle.
  - An interrupt arriving while busy is deferred, not lost while it remains asserted.
- Arithmetic: pc_M-4 is modulo 2^32; 32'h0 in a delay slot yields 32'hFFFF_FFFC.
- Reset asserted mid-FLUSH or mid-REDIRECT aborts immediately to reset values; no redirect is issued.

Test Plan:
- Exception, exl=0: m_valid=1, pc_M=0x3010, bd_M=0, exc_valid_M=1, exc_code_M=4 → EXC_flush high for 1 cycle; epc=0x3010, cause_code=4, exl=1; next cycle pc_redirect_valid=1, pc_redirect=0x4180.
- Delay slot: exc_valid_M=1, pc_M=0x3020, bd_M=1 → epc=0x301C, cause_bd=1.
- Interrupt beats exception: cfg write {ie=1, im=6'b000100}; int_req=6'b000100 with exc_valid_M=1 in the same cycle → cause_code=0; cause_ip=6'b000100 the following cycle.
- Nested exception: exl=1, epc=0x3010; exception at pc_M=0x4190 → epc stays 0x3010; redirect to 0x4180.
- Eret: exl=1, epc=0x3010, eret_M=1 → exl=0 after the edge; pc_redirect=0x3010 after 1 flush cycle.
- Masked/busy/reset cases:
  - int_req high with ie=0 → no flush.
  - int_req high during FLUSH → taken on the first RUN cycle with m_valid=1 and ie=1.
  - FLUSH_CYCLES=3 → EXC_flush high for exactly 3 cycles.
  - reset asserted mid-FLUSH → all outputs 0 without waiting for a clock edge; pc_redirect_valid never pulses.
